call_ret_seq: RTL and testbench

Multi-cycle sequencer that carries out the register-file save on CALL and the restore on RET.
- Consumes the mode request (0 none, 1 CALL, 2 RET, 3 reserved) issued by the instruction decoder.
- Moves all NREGS registers between the register file and data memory, one word per mem_ack.
- Drives the step counter `sc` back to the decoder; `sc == NREGS` marks completion.
- Stalls the core while busy and updates the stack pointer when the transfer finishes.

---
 rtl/call_ret_seq_if.sv | 40 ++++
 rtl/call_ret_seq.sv | 106 ++++++++++
 tb/tb_call_ret_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/call_ret_seq_if.sv
// Sequencer-side bundle: decoder request/feedback, register-file port,
// memory port and stack-pointer update.
interface call_ret_seq_if #(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
);
    localparam int IDXW = $clog2(NREGS);

    logic [1:0]      mode_req;
    logic [XLEN-1:0] sp_in;
    logic            busy;
    logic [1:0]      state_mode;
    logic [7:0]      sc;
    logic [IDXW-1:0] rf_raddr;
    logic [XLEN-1:0] rf_rdata;
    logic [IDXW-1:0] rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            rf_we;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;
    logic [XLEN-1:0] sp_out;
    logic            sp_we;
    logic            done;

    modport master (
        input  mode_req, sp_in, rf_rdata, mem_rdata, mem_ack,
        output busy, state_mode, sc, rf_raddr, rf_waddr, rf_wdata, rf_we,
               mem_req, mem_we, mem_addr, mem_wdata, sp_out, sp_we, done
    );

    modport slave (
        output mode_req, sp_in, rf_rdata, mem_rdata, mem_ack,
        input  busy, state_mode, sc, rf_raddr, rf_waddr, rf_wdata, rf_we,
               mem_req, mem_we, mem_addr, mem_wdata, sp_out, sp_we, done
    );
endinterface

// File: rtl/call_ret_seq.sv
// CALL/RET register-file save/restore sequencer: moves NREGS words between the
// register file and a stack frame, one word per memory ack, then updates SP.
module call_ret_seq #(
    parameter int NREGS  = 16,
    parameter int XLEN   = 32,
    parameter int WBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    call_ret_seq_if.master bus
);
    localparam int              IDXW    = $clog2(NREGS);
    localparam logic [XLEN-1:0] FRAME   = XLEN'(WBYTES * NREGS);
    localparam logic [XLEN-1:0] STRIDE  = XLEN'(WBYTES);
    localparam logic [7:0]      SC_LAST = 8'(NREGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [7:0]      sc_q, sc_d;
    logic [XLEN-1:0] base_q, base_d;
    logic            is_call;

    assign is_call        = (mode_q == 2'd1);
    assign bus.state_mode = mode_q;
    assign bus.sc         = sc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 2'd0;
            sc_q    <= 8'd0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sc_q    <= sc_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        sc_d          = sc_q;
        base_d        = base_q;
        bus.busy      = 1'b0;
        bus.rf_raddr  = '0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.rf_we     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.sp_out    = '0;
        bus.sp_we     = 1'b0;
        bus.done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.mode_req == 2'd1 || bus.mode_req == 2'd2) begin
                    mode_d  = bus.mode_req;
                    // CALL pushes a fresh frame below SP; RET pops the frame at SP.
                    base_d  = (bus.mode_req == 2'd1) ? (bus.sp_in - FRAME) : bus.sp_in;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                bus.busy     = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = base_q + XLEN'(sc_q) * STRIDE;
                if (is_call) begin
                    bus.mem_we    = 1'b1;
                    bus.rf_raddr  = sc_q[IDXW-1:0];
                    bus.mem_wdata = bus.rf_rdata;
                end else begin
                    bus.rf_waddr = sc_q[IDXW-1:0];
                    bus.rf_wdata = bus.mem_rdata;
                    bus.rf_we    = bus.mem_ack;
                end
                if (bus.mem_ack) begin
                    sc_d = sc_q + 8'd1;
                    if (sc_q == SC_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                bus.sp_we  = 1'b1;
                bus.sp_out = is_call ? base_q : (base_q + FRAME);
                state_d    = S_IDLE;
                sc_d       = 8'd0;
                mode_d     = 2'd0;
            end
            default: begin
                state_d = S_IDLE;
                sc_d    = 8'd0;
                mode_d  = 2'd0;
            end
        endcase
    end
endmodule

// File: tb/tb_call_ret_seq.sv
// Directed bench for call_ret_seq: table of whole CALL/RET sequences plus
// hand-written wait-state, reserved-request and mid-sequence reset cases.
module tb_call_ret_seq;
    localparam int NREGS = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    call_ret_seq_if #(.NREGS(NREGS), .XLEN(32)) bus ();

    call_ret_seq #(.NREGS(NREGS), .XLEN(32), .WBYTES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int checks = 0;
    int failures = 0;

    // Memory and register-file models.
    logic [31:0] mem [0:1023];
    logic [31:0] regs [0:NREGS-1];
    int          period = 1;
    int          wcnt = 0;
    logic        stray = 1'b0;
    logic [1:0]  rf_cmd = 2'd0;

    always_comb bus.mem_ack   = (bus.mem_req && (wcnt == period - 1)) || stray;
    always_comb bus.mem_rdata = mem[bus.mem_addr[11:2]];
    always_comb bus.rf_rdata  = regs[bus.rf_raddr];

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (bus.mem_req && bus.mem_ack && bus.mem_we)
            mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    always @(posedge clk) begin
        if (rf_cmd == 2'd1) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 32'hA0 + 32'(i);
        end else if (rf_cmd == 2'd2) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0;
        end else if (bus.rf_we) begin
            regs[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    // rf_we only inside a RET transfer, mem_we only inside a CALL transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((bus.rf_we && !(bus.busy && bus.mem_req && bus.state_mode == 2'd2)) ||
                (bus.mem_we && !(bus.mem_req && bus.state_mode == 2'd1))) begin
                failures++;
                $display("FAIL strobe_scope: rf_we=%b mem_we=%b mode=%0d mem_req=%b required no stray write strobe",
                         bus.rf_we, bus.mem_we, bus.state_mode, bus.mem_req);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [31:0] sp;
        int          period;
        int          poke;
        logic [31:0] exp_base;
        logic [31:0] exp_spout;
        int          exp_done;
    } vec_t;

    vec_t vecs [5];

    task automatic rf_pulse(input logic [1:0] c);
        @(negedge clk); rf_cmd = c;
        @(negedge clk); rf_cmd = 2'd0;
    endtask

    task automatic run_seq(input int idx);
        vec_t        v;
        int          beat;
        bit          got;
        logic [31:0] exp_addr;
        v = vecs[idx];
        period = v.period;
        @(negedge clk);
        bus.mode_req = v.mode;
        bus.sp_in    = v.sp;
        beat = 0;
        got  = 1'b0;
        for (int c = 1; c <= 400 && !got; c++) begin
            @(negedge clk);
            bus.mode_req = (c == v.poke) ? 2'd2 : 2'd0;
            if (bus.mem_req) begin
                exp_addr = v.exp_base + 32'(4 * beat);
                chk({v.name, "_addr"}, bus.mem_addr, exp_addr);
                chk({v.name, "_sc"}, 32'(bus.sc), 32'(beat));
                chk({v.name, "_mode"}, 32'(bus.state_mode), 32'(v.mode));
                chk({v.name, "_busy"}, 32'(bus.busy), 32'd1);
                if (v.mode == 2'd2) begin
                    chk({v.name, "_rfwe"}, 32'(bus.rf_we), 32'(bus.mem_ack));
                    chk({v.name, "_rfwaddr"}, 32'(bus.rf_waddr), 32'(beat));
                    chk({v.name, "_rfwdata"}, bus.rf_wdata, 32'hA0 + 32'(beat));
                end else begin
                    chk({v.name, "_memwe"}, 32'(bus.mem_we), 32'd1);
                    chk({v.name, "_memwdata"}, bus.mem_wdata, 32'hA0 + 32'(beat));
                end
                if (bus.mem_ack) beat++;
            end else if (bus.done) begin
                chk({v.name, "_done_cycle"}, 32'(c), 32'(v.exp_done));
                chk({v.name, "_sp_out"}, bus.sp_out, v.exp_spout);
                chk({v.name, "_sp_we"}, 32'(bus.sp_we), 32'd1);
                chk({v.name, "_sc_final"}, 32'(bus.sc), 32'(NREGS));
                chk({v.name, "_beats"}, 32'(beat), 32'(NREGS));
                chk({v.name, "_busy_done"}, 32'(bus.busy), 32'd1);
                got = 1'b1;
            end else begin
                chk({v.name, "_active"}, {bus.busy, bus.mem_req, bus.done}, 32'h7);
                got = 1'b1;
            end
        end
        if (!got) chk({v.name, "_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        chk({v.name, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({v.name, "_idle_sc"}, 32'(bus.sc), 32'd0);
        chk({v.name, "_idle_mode"}, 32'(bus.state_mode), 32'd0);
        chk({v.name, "_idle_done"}, {bus.done, bus.sp_we, bus.mem_req}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"call0", 2'd1, 32'h0000_1000, 1, 0, 32'h0000_0FC0, 32'h0000_0FC0, 17};
        vecs[1] = '{"ret0",  2'd2, 32'h0000_0FC0, 1, 0, 32'h0000_0FC0, 32'h0000_1000, 17};
        vecs[2] = '{"callw", 2'd1, 32'h0000_1000, 3, 0, 32'h0000_0FC0, 32'h0000_0FC0, 49};
        vecs[3] = '{"poke",  2'd1, 32'h0000_1000, 1, 4, 32'h0000_0FC0, 32'h0000_0FC0, 17};
        vecs[4] = '{"wrap",  2'd1, 32'h0000_0020, 1, 0, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 17};

        bus.mode_req = 2'd0;
        bus.sp_in    = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {bus.busy, bus.mem_req, bus.done, bus.sp_we, bus.rf_we, bus.mem_we}, 32'd0);
        chk("rst_sc", 32'(bus.sc), 32'd0);
        chk("rst_mode", 32'(bus.state_mode), 32'd0);
        chk("rst_sp_out", bus.sp_out, 32'd0);
        rst_n = 1'b1;
        rf_pulse(2'd1);

        for (int i = 0; i < 5; i++) begin
            if (i == 1) rf_pulse(2'd2);
            run_seq(i);
            if (i == 0)
                for (int r = 0; r < NREGS; r++) chk("call0_mem", mem[10'h3F0 + 10'(r)], 32'hA0 + 32'(r));
            if (i == 1)
                for (int r = 0; r < NREGS; r++) chk("ret0_regs", regs[r], 32'hA0 + 32'(r));
        end

        // Reserved request and stray ack in IDLE must not start anything.
        @(negedge clk);
        bus.mode_req = 2'd3;
        stray = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mode3_idle", {bus.busy, bus.mem_req, bus.done, bus.sp_we}, 32'd0);
            chk("mode3_mode", 32'(bus.state_mode), 32'd0);
        end
        bus.mode_req = 2'd0;
        stray = 1'b0;

        // Asynchronous reset after five CALL beats.
        period = 1;
        @(negedge clk);
        bus.mode_req = 2'd1;
        bus.sp_in    = 32'h0000_1000;
        @(negedge clk);
        bus.mode_req = 2'd0;
        repeat (5) @(negedge clk);
        chk("midrst_sc_before", 32'(bus.sc), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_strobes", {bus.busy, bus.mem_req, bus.done, bus.sp_we, bus.rf_we, bus.mem_we}, 32'd0);
        chk("midrst_sc", 32'(bus.sc), 32'd0);
        chk("midrst_mode", 32'(bus.state_mode), 32'd0);
        chk("midrst_addr", bus.mem_addr, 32'd0);
        chk("midrst_sp_out", bus.sp_out, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", {bus.done, bus.sp_we}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_idle", {bus.busy, bus.done, bus.sp_we}, 32'd0);
        run_seq(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
